// File: rtl/mux3_sel_arbiter_pkg.sv
// mux3_sel_pkg: shared types and helpers for the 3:1 mux select arbiter.
//   - SEL_I*     : select codes {s1,s0} driven to the downstream 3:1 mux
//   - state_e    : arbiter FSM states
//   - grant_t    : one-hot grant plus matching select code for one index
//   - idx_to_grant / next_idx : index helpers shared by arbiter and picker
package mux3_sel_pkg;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] onehot;
        logic [1:0] sel;
    } grant_t;

    // Index 3 is not a legal requester; it folds onto input 2 so the
    // select code 11 can never be produced.
    function automatic grant_t idx_to_grant(input logic [1:0] idx);
        grant_t g;
        case (idx)
            2'd0:    begin g.onehot = 3'b001; g.sel = SEL_I0; end
            2'd1:    begin g.onehot = 3'b010; g.sel = SEL_I1; end
            default: begin g.onehot = 3'b100; g.sel = SEL_I2; end
        endcase
        return g;
    endfunction

    // Circular successor over 0,1,2.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/mux3_sel_arbiter_if.sv
// mux3_sel_arbiter_if: request/select bundle between the requesters, the
// arbiter and the 3:1 data mux.
//   req  : per-input request (requester side drives)
//   gnt  : one-hot grant, 000 when idle
//   s1/s0: mux select code
//   busy : any grant active
// Modports: master = requester/mux side, slave = arbiter.
interface mux3_sel_arbiter_if;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;

    modport master (output req, input gnt, s0, s1, busy);
    modport slave  (input req, output gnt, s0, s1, busy);
endinterface

// File: rtl/mux3_sel_arbiter_rr_pick3.sv
// rr_pick3: combinational circular priority scan over three requesters.
//   req      : request vector
//   start    : first index examined; scan continues start, start+1, ... mod 3
//   mask_en  : when set, mask_idx is excluded from the scan
//   mask_idx : index to exclude
//   found    : some unmasked request exists
//   idx      : winning index (0 when nothing found)
module rr_pick3
    import mux3_sel_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] start,
    input  logic       mask_en,
    input  logic [1:0] mask_idx,
    output logic       found,
    output logic [1:0] idx
);

    grant_t     mask_g;
    logic [2:0] cand;
    logic [1:0] pos0, pos1, pos2;

    always_comb begin
        mask_g = idx_to_grant(mask_idx);
        cand   = mask_en ? (req & ~mask_g.onehot) : req;

        pos0 = (start > 2'd2) ? 2'd0 : start;
        pos1 = next_idx(pos0);
        pos2 = next_idx(pos1);

        found = 1'b1;
        idx   = 2'd0;
        if (cand[pos0])      idx = pos0;
        else if (cand[pos1]) idx = pos1;
        else if (cand[pos2]) idx = pos2;
        else                 found = 1'b0;
    end

endmodule

// File: rtl/mux3_sel_arbiter.sv
// mux3_sel_arbiter: round-robin arbiter producing the {s1,s0} select pair
// for a 3:1 data mux. One requester is granted at a time; the grant is cut
// after HOLD_CYCLES cycles only when someone else is waiting.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mux3_sel_arbiter_if (req in; gnt, s1, s0, busy out)
module mux3_sel_arbiter
    import mux3_sel_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux3_sel_arbiter_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] start_idx;
    logic       mask_en;
    grant_t     cur_g, win_g;
    logic       others;
    logic       rel;

    // While granted, last_q is the current owner, so one picker instance
    // serves both IDLE arbitration and GRANT re-arbitration. The owner is
    // excluded only while it still requests.
    assign start_idx = next_idx(last_q);
    assign mask_en   = (state_q == GRANT) && bus.req[last_q];

    rr_pick3 u_pick (
        .req      (bus.req),
        .start    (start_idx),
        .mask_en  (mask_en),
        .mask_idx (last_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        cur_g  = idx_to_grant(last_q);
        win_g  = idx_to_grant(pick_idx);
        others = |(bus.req & ~cur_g.onehot);
        rel    = !bus.req[last_q] || ((cnt_q == CNT_LAST) && others);

        case (state_q)
            IDLE: begin
                gnt_d = 3'b000;
                if (pick_found) begin
                    gnt_d   = win_g.onehot;
                    sel_d   = win_g.sel;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    if (pick_found) begin
                        // Hand over directly, no idle bubble.
                        gnt_d  = win_g.onehot;
                        sel_d  = win_g.sel;
                        last_d = pick_idx;
                        cnt_d  = '0;
                    end else begin
                        // Select stays put so the mux output does not glitch.
                        gnt_d   = 3'b000;
                        state_d = IDLE;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= SEL_I0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.s1   = sel_q[1];
    assign bus.s0   = sel_q[0];
    assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_mux3_sel_arbiter.sv
// tb_mux3_sel_arbiter: directed scoreboard bench. The driver applies one
// vector per cycle on the falling edge and queues the hand-computed state
// expected after the next rising edge; the monitor pops and compares one
// entry per cycle just after each rising edge.
module tb_mux3_sel_arbiter;

    typedef struct {
        logic [2:0] gnt;
        logic [1:0] sel;
    } exp_t;

    localparam logic [2:0] I_VEC = 3'b101;  // i2=1, i1=0, i0=1

    logic clk;
    logic rst;
    logic y;
    exp_t exp_q[$];
    int   n_pass;
    int   n_total;

    mux3_sel_arbiter_if bus ();

    mux3_sel_arbiter #(
        .HOLD_CYCLES (4),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Downstream 3:1 mux fed by the arbiter's select pair.
    always_comb begin
        case ({bus.s1, bus.s0})
            2'b00:   y = I_VEC[0];
            2'b01:   y = I_VEC[1];
            default: y = I_VEC[2];
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    endtask

    task automatic step(input logic r, input logic [2:0] rq,
                        input logic [2:0] eg, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        e.gnt   = eg;
        e.sel   = es;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt",  {5'd0, bus.gnt}, {5'd0, e.gnt});
                chk("sel",  {6'd0, bus.s1, bus.s0}, {6'd0, e.sel});
                chk("busy", {7'd0, bus.busy}, {7'd0, |e.gnt});
                chk("sel_not_11", {7'd0, bus.s1 & bus.s0}, 8'd0);
                if (e.gnt != 3'b000)
                    chk("mux_y", {7'd0, y}, {7'd0, |(e.gnt & I_VEC)});
            end
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.req = 3'b000;

        // Reset state
        step(1, 3'b000, 3'b000, 2'b00);
        step(1, 3'b000, 3'b000, 2'b00);

        // Single requester 0, then drop: IDLE, select holds 00
        step(0, 3'b001, 3'b001, 2'b00);
        repeat (3) step(0, 3'b001, 3'b001, 2'b00);
        step(0, 3'b000, 3'b000, 2'b00);
        step(0, 3'b000, 3'b000, 2'b00);

        // Reset, then req=110: input 1 first, 4 cycles, then input 2
        step(1, 3'b000, 3'b000, 2'b00);
        repeat (4) step(0, 3'b110, 3'b010, 2'b01);
        repeat (4) step(0, 3'b110, 3'b100, 2'b10);
        repeat (2) step(0, 3'b110, 3'b010, 2'b01);
        step(0, 3'b000, 3'b000, 2'b01);   // idle, select held at 01

        // Reset, then all three requesting: 0,1,2,0,1,2 at 4 cycles each
        step(1, 3'b000, 3'b000, 2'b00);
        for (int r = 0; r < 24; r++) begin
            case ((r / 4) % 3)
                0:       step(0, 3'b111, 3'b001, 2'b00);
                1:       step(0, 3'b111, 3'b010, 2'b01);
                default: step(0, 3'b111, 3'b100, 2'b10);
            endcase
        end
        step(0, 3'b000, 3'b000, 2'b10);   // idle, select held at 10

        // Lone requester 2 for 20 cycles: no re-grant, no drop
        repeat (20) step(0, 3'b100, 3'b100, 2'b10);

        // Reset mid-grant of input 2, then req=111: input 0 first
        step(1, 3'b100, 3'b000, 2'b00);
        repeat (4) step(0, 3'b111, 3'b001, 2'b00);
        step(0, 3'b111, 3'b010, 2'b01);
        step(0, 3'b000, 3'b000, 2'b01);

        // last=1: owner 1 drops while 0 and 2 rise -> 2 wins (scan 2,0,1)
        step(0, 3'b010, 3'b010, 2'b01);
        step(0, 3'b101, 3'b100, 2'b10);
        step(0, 3'b000, 3'b000, 2'b10);

        repeat (3) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux3_sel_arbiter.md
Name: mux3_sel_arbiter

Overview:
Round-robin arbiter that produces the select pair {s1,s0} for the 3:1 data mux (inputs i0, i1, i2; output y).
- Three requesters raise req; the block grants one at a time and drives the matching select code, held stable for the whole grant.
- A hold-cycle limit bounds the grant length when other requesters are waiting.
- Sits directly upstream of the mux and drives its select inputs.

Parameters:
- HOLD_CYCLES, 4: maximum cycles one grant is held while another requester is pending; legal range 1..15.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request per mux input; bit n = in for n=0..2.
- s0  output  1  mux select LSB, registered.
- s1  output  1  mux select MSB, registered.
- gnt  output  3  one-hot grant, registered; 000 when idle.
- busy  output  1  high while any grant is active (equals |gnt).

Behaviour:
- Select encoding: grant to input 0 drives {s1,s0}=00, input 1 drives 01, input 2 drives 10. Code 11 is never driven.
- Reset, synchronous: at a rising edge with rst=1, outputs go to s1=0, s0=0, gnt=000, busy=0; state goes to IDLE, hold counter to 0, last pointer to 2 so input 0 has highest priority first.
  - rst has priority over every other event.
  - Asserting rst mid-grant drops the grant at that edge.
- State IDLE:
  - If req != 000, choose the first set bit scanning circularly from last+1 (e.g. last=2 scans 0,1,2).
  - At the next edge: load gnt, load s1/s0, last=chosen, counter=0, go to GRANT.
  - Latency is 1 cycle from req to gnt.
  - If req == 000, stay in IDLE; s1/s0 keep their last value so the mux output does not glitch; gnt=000.
- State GRANT, granted index g:
  - The counter increments each cycle and saturates at HOLD_CYCLES.
  - Release condition: req[g]=0, or (counter==HOLD_CYCLES-1 and another req bit is set).
  - On release, re-arbitrate in the same cycle, scanning from g+1 and excluding g when g still requests.
    - If a winner exists, the next edge loads the new grant directly with no idle bubble, and the counter resets to 0.
    - If no winner exists and req[g]=0, go to IDLE with gnt=000 and s1/s0 holding.
  - If req[g] stays high and no other requester is pending, the grant continues indefinitely and the counter saturates (no wrap).
  - A request that appears mid-grant is never served before the current grant releases.
- Simultaneous events:
  - req[g] falling in the same cycle a new request rises: the new requester wins per round-robin order.
  - All three requesting continuously: each holds exactly HOLD_CYCLES cycles, in order 0,1,2,0,...
- Invariants: gnt is always zero or one-hot; gnt and {s1,s0} change only at the same edge.

Decomposition:
- Package mux3_sel_pkg holds:
  - localparams SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10;
  - state enum {IDLE, GRANT};
  - a function mapping an index to its one-hot value and select code.
- One combinational sub-module, rr_pick3: inputs req[2:0], start[1:0], mask_en, mask_idx[1:0]; outputs found and idx[1:0]. It implements the circular priority scan and is reused for both IDLE and GRANT re-arbitration.

Test Plan:
- Reset then req=001 held: gnt=001 and s1s0=00 one cycle after req; busy=1; drop req gives IDLE next edge, gnt=000, s1s0 still 00.
- req=110 from IDLE after reset: input 1 wins (s1s0=01); after 4 cycles input 2 is granted (s1s0=10) with no idle cycle.
- req=111 held for 24 cycles, HOLD_CYCLES=4: grants rotate 0,1,2,0,1,2, 4 cycles each; gnt is never 000 and s1s0 is never 11.
- req=100 held alone for 20 cycles: gnt stays 100 for all 20 cycles; counter saturates at 4 with no re-grant.
- rst=1 pulsed for one cycle mid-grant of input 2: next edge gives gnt=000, s1s0=00; after rst drops with req=111, input 0 is granted first.
- Feed s1/s0 into the 3:1 mux with i0=1, i1=0, i2=1: y tracks the granted input each cycle, checked against the gnt index.
